xor_flip_sched: RTL and testbench
=================================

Name: xor_flip_sched

Overview:
- Round-robin scheduler that shares one pair-flip datapath among NREQ requesters. Each requester asks to toggle a single bit of a W-bit register.
- The block pairs single-bit requests into distinct-index pairs and issues at most one pair per cycle. It owns the flipped register q.
- Invariant: q always holds even parity. Unpaired requests wait in a one-entry hold slot.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, width of q; power of two.
- IDX_W, $clog2(W), bit-index width (5 at default).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NREQ  requester k has a pending bit index.
- req_idx  input  NREQ*IDX_W  bit index of requester k, in slice [k*IDX_W +: IDX_W].
- req_ready  output  NREQ  requester k granted this cycle; accept = valid & ready.
- flip_valid  output  1  registered; pair issued to q this cycle.
- flip_i  output  IDX_W  registered first index of the issued pair.
- flip_j  output  IDX_W  registered second index; differs from flip_i whenever flip_valid=1.
- held_valid  output  1  hold slot occupied.
- held_idx  output  IDX_W  index in hold slot.
- cancel_pulse  output  1  registered; an equal-index pair was annihilated last cycle.
- q  output  W  flipped register.

Behaviour:
- Reset (rst_n=0 at a clock edge): q=0, flip_valid=0, flip_i=0, flip_j=0, held_valid=0, held_idx=0, cancel_pulse=0, rr_ptr=0. While rst_n=0, req_ready=0 combinationally. Reset mid-operation discards the held entry and any in-flight pair.
- Grant, combinational: budget B=1 if held_valid, else B=2. Scan requesters from rr_ptr upward, modulo NREQ. Grant the first B with req_valid=1.
- rr_ptr updates to (last granted + 1) mod NREQ. It is unchanged if nothing was granted.
- Candidate list each cycle: the held entry (if valid), then the granted indices in scan order. Size is 0, 1 or 2.
  - Size 0: no change.
  - Size 1: the candidate goes to the hold slot: held_valid=1, held_idx=idx.
  - Size 2, distinct indices (a,b): next cycle flip_valid=1, flip_i=a, flip_j=b. Hold slot is cleared.
  - Size 2, equal indices: both are consumed and nothing is issued. Next cycle cancel_pulse=1. Hold slot is cleared.
- Issue to q: on the edge after flip_valid=1 is registered, q[flip_i] and q[flip_j] toggle. Accept-to-q latency is 2 cycles.
- flip_valid and cancel_pulse are single-cycle pulses. They are never both 1.
- No backpressure from the datapath. One pair per cycle is always absorbed.
- Required invariants, embedded as assertions gated by rst_n:
  - ^q == 0.
  - flip_valid implies flip_i != flip_j.
  - At most 2 requests accepted per cycle, and at most 1 when held_valid=1.
  - q ^ pending_flip_mask ^ (held_valid ? 1<<held_idx : 0) equals the XOR of one-hot masks of all requests accepted since reset.
  - A requester with req_valid continuously asserted is granted within NREQ cycles.
- Formal environment constraint: !rst_n == $initstate.

Decomposition:
- Shared package xor_flip_pkg holds:
  - constants W and IDX_W;
  - typedef flip_idx_t = logic [IDX_W-1:0];
  - typedef flip_pair_t = struct {flip_idx_t i; flip_idx_t j;};
  - function onehot(flip_idx_t) returning logic [W-1:0].
- One natural sub-module: rr_pick2. It is a combinational round-robin picker returning up to two grant positions (budget 1 or 2) and the next rr_ptr.
- The pairing/hold logic and q live in xor_flip_sched.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, q=0, held_valid=0. After release, the first grant goes to req0 and req1 (rr_ptr=0).
- Single request: req2 idx=7 for one cycle -> held_valid=1, held_idx=7, no flip. Then req0 idx=12 -> flip_valid=1, flip_i=7, flip_j=12. Two cycles later q=0x0000_1080.
- Same-cycle pair: req1 idx=3 and req3 idx=31, hold empty -> both ready, flip_i=3, flip_j=31. q becomes 0x8000_0008; a repeat returns q to 0.
- Cancellation: hold has idx=5, and req0 idx=5 arrives -> req0 accepted, held_valid=0, cancel_pulse=1, flip_valid=0, q unchanged.
- Fairness: all 4 requesters valid continuously, hold empty -> grants {0,1},{2,3},{0,1}… and every requester is granted within 4 cycles. With one leftover held, the budget drops to 1 per cycle.
- Reset mid-operation: held_valid=1 (idx=9) and flip_valid=1 in flight, assert rst_n=0 -> next cycle q=0, held_valid=0, flip_valid=0. Parity assertion holds throughout.

Source files
------------

// File: rtl/xor_flip_pkg.sv
// xor_flip_pkg: shared constants, index/pair types and one-hot helper for the pair-flip scheduler
package xor_flip_pkg;
  localparam int W = 32;
  localparam int IDX_W = $clog2(W);
  typedef logic [IDX_W-1:0] flip_idx_t;
  typedef struct packed {
    flip_idx_t i;
    flip_idx_t j;
  } flip_pair_t;
  function automatic logic [W-1:0] onehot(flip_idx_t idx);
    return W'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational round-robin picker granting up to one or two requesters per cycle
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  input  logic            two,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   pos0,
  output logic [PW-1:0]   pos1,
  output logic [1:0]      n,
  output logic [PW-1:0]   ptr_nxt
);
  // scan from ptr upward, take the first one or two valid requesters, pointer moves past the last one taken
  always_comb begin
    grant = '0;
    pos0 = '0;
    pos1 = '0;
    n = 2'd0;
    ptr_nxt = ptr;
    for (int o = 0; o < NREQ; o++) begin
      int k;
      k = (int'(ptr) + o) % NREQ;
      if (valid[k] && n < (two ? 2'd2 : 2'd1)) begin
        grant[k] = 1'b1;
        if (n == 2'd0) pos0 = PW'(k);
        else pos1 = PW'(k);
        n = n + 2'd1;
        ptr_nxt = PW'((k + 1) % NREQ);
      end
    end
  end
endmodule

// File: rtl/xor_flip_sched.sv
// xor_flip_sched: pairs single-bit flip requests and toggles two distinct bits of q per issued pair
module xor_flip_sched
  import xor_flip_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*IDX_W-1:0] req_idx,
  output logic [NREQ-1:0]       req_ready,
  output logic                  flip_valid,
  output logic [IDX_W-1:0]      flip_i,
  output logic [IDX_W-1:0]      flip_j,
  output logic                  held_valid,
  output logic [IDX_W-1:0]      held_idx,
  output logic                  cancel_pulse,
  output logic [W-1:0]          q
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, pos0, pos1;
  logic [NREQ-1:0] grant;
  logic [1:0] n_gnt, n_cand;
  flip_idx_t g0_idx, g1_idx, cand_a, cand_b, held_idx_q, held_idx_d;
  flip_pair_t flip_q, flip_d;
  logic flip_valid_q, flip_valid_d, cancel_q, cancel_d, held_valid_q, held_valid_d;
  logic [W-1:0] q_q, q_d, acc_q, acc_d, pend_mask, held_mask;
  logic [3:0] wait_q [NREQ];
  rr_pick2 #(.NREQ(NREQ)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr_q),
    .two(!held_valid_q),
    .grant(grant),
    .pos0(pos0),
    .pos1(pos1),
    .n(n_gnt),
    .ptr_nxt(rr_ptr_d)
  );
  assign req_ready = rst_n ? grant : '0;
  assign g0_idx = req_idx[pos0*IDX_W +: IDX_W];
  assign g1_idx = req_idx[pos1*IDX_W +: IDX_W];
  assign n_cand = {1'b0, held_valid_q} + n_gnt;
  assign cand_a = held_valid_q ? held_idx_q : g0_idx;
  assign cand_b = held_valid_q ? g0_idx : g1_idx;
  // pairing: one candidate parks in the hold slot, two distinct issue, two equal annihilate
  always_comb begin
    flip_valid_d = n_cand == 2'd2 && cand_a != cand_b;
    cancel_d = n_cand == 2'd2 && cand_a == cand_b;
    flip_d = flip_valid_d ? flip_pair_t'{cand_a, cand_b} : flip_q;
    held_valid_d = n_cand == 2'd1 ? 1'b1 : n_cand == 2'd2 ? 1'b0 : held_valid_q;
    held_idx_d = n_cand == 2'd1 ? cand_a : held_idx_q;
    q_d = flip_valid_q ? q_q ^ onehot(flip_q.i) ^ onehot(flip_q.j) : q_q;
  end
  // state registers; reset drops the hold slot and any pair in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
      flip_q <= '0;
      flip_valid_q <= 1'b0;
      cancel_q <= 1'b0;
      held_valid_q <= 1'b0;
      held_idx_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      q_q <= q_d;
      flip_q <= flip_d;
      flip_valid_q <= flip_valid_d;
      cancel_q <= cancel_d;
      held_valid_q <= held_valid_d;
      held_idx_q <= held_idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign flip_valid = flip_valid_q;
  assign flip_i = flip_q.i;
  assign flip_j = flip_q.j;
  assign held_valid = held_valid_q;
  assign held_idx = held_idx_q;
  assign cancel_pulse = cancel_q;
  assign q = q_q;
  // running XOR of every accepted request, used to check that no flip is ever lost
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[k] && req_ready[k]) acc_d = acc_d ^ onehot(req_idx[k*IDX_W +: IDX_W]);
  end
  assign pend_mask = flip_valid_q ? onehot(flip_q.i) ^ onehot(flip_q.j) : '0;
  assign held_mask = held_valid_q ? onehot(held_idx_q) : '0;
  // shadow tracking: accepted-flip accumulator and per-requester consecutive wait counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      for (int k = 0; k < NREQ; k++) wait_q[k] <= '0;
    end else begin
      acc_q <= acc_d;
      for (int k = 0; k < NREQ; k++) wait_q[k] <= (req_valid[k] && !req_ready[k]) ? wait_q[k] + 4'd1 : 4'd0;
    end
  end
  // invariants: even parity, distinct pair, accept budget, flip conservation, bounded wait
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (^q_q == 1'b0);
      assert (!flip_valid_q || flip_q.i != flip_q.j);
      assert (!(flip_valid_q && cancel_q));
      assert ($countones(req_valid & req_ready) <= (held_valid_q ? 1 : 2));
      assert ((q_q ^ pend_mask ^ held_mask) == acc_q);
      for (int k = 0; k < NREQ; k++) assert (int'(wait_q[k]) < NREQ);
    end
  end
endmodule

// File: tb/tb_xor_flip_sched.sv
// tb_xor_flip_sched: directed and randomized checks against a queue-based pairing model
module tb_xor_flip_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0;
  logic [19:0] req_idx = '0;
  logic [3:0] req_ready;
  logic flip_valid, held_valid, cancel_pulse;
  logic [4:0] flip_i, flip_j, held_idx;
  logic [31:0] q;
  int errs = 0;
  int checks = 0;
  bit m_hv, m_fv, m_cp;
  int m_hi, m_fi, m_fj, m_ptr, m_last;
  logic [31:0] m_q;
  logic [3:0] exp_ready;
  int gq[$];

  xor_flip_sched #(.NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .flip_valid(flip_valid), .flip_i(flip_i), .flip_j(flip_j), .held_valid(held_valid),
    .held_idx(held_idx), .cancel_pulse(cancel_pulse), .q(q)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] pk(int a0, int a1, int a2, int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic model_grant();
    int budget;
    exp_ready = '0;
    gq.delete();
    m_last = -1;
    if (!rst_n) return;
    budget = m_hv ? 1 : 2;
    for (int o = 0; o < 4; o++) begin
      int k;
      k = (m_ptr + o) % 4;
      if (req_valid[k] && gq.size() < budget) begin
        exp_ready[k] = 1'b1;
        gq.push_back(int'(req_idx[k*5 +: 5]));
        m_last = k;
      end
    end
  endtask

  task automatic model_clock();
    int c[$];
    if (!rst_n) begin
      m_hv = 0; m_hi = 0; m_fv = 0; m_fi = 0; m_fj = 0; m_cp = 0; m_ptr = 0; m_q = '0;
      return;
    end
    if (m_fv) m_q = m_q ^ (32'd1 << m_fi) ^ (32'd1 << m_fj);
    if (m_hv) c.push_back(m_hi);
    foreach (gq[n]) c.push_back(gq[n]);
    m_fv = 0;
    m_cp = 0;
    if (c.size() == 1) begin
      m_hv = 1; m_hi = c[0];
    end else if (c.size() == 2) begin
      m_hv = 0;
      if (c[0] != c[1]) begin m_fv = 1; m_fi = c[0]; m_fj = c[1]; end
      else m_cp = 1;
    end
    if (m_last >= 0) m_ptr = (m_last + 1) % 4;
  endtask

  task automatic tick();
    model_grant();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(logic [3:0] v, logic [19:0] idx);
    req_valid = v;
    req_idx = idx;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0, '0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'hF, pk(0, 1, 2, 3));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0) begin errs++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      checks++; if (q !== 32'h0) begin errs++; $display("FAIL reset_q got=%h want=0", q); end
      checks++; if (held_valid !== 1'b0) begin errs++; $display("FAIL reset_held got=%b want=0", held_valid); end
      checks++; if (flip_valid !== 1'b0 || cancel_pulse !== 1'b0) begin errs++; $display("FAIL reset_pulses got=%b%b want=00", flip_valid, cancel_pulse); end
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0011) begin errs++; $display("FAIL reset_first_grant got=%b want=0011", req_ready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0100, pk(0, 0, 7, 0));
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    tick();
    drive(4'b0001, pk(12, 0, 0, 0));
    @(negedge clk);
    checks++; if (held_valid !== 1'b1 || held_idx !== 5'd7) begin errs++; $display("FAIL single_held got=%b/%0d want=1/7", held_valid, held_idx); end
    checks++; if (flip_valid !== 1'b0) begin errs++; $display("FAIL single_noflip got=%b want=0", flip_valid); end
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_budget1 got=%b want=0001", req_ready); end
    tick();
    drive(4'b0, '0);
    @(negedge clk);
    checks++; if (flip_valid !== 1'b1 || flip_i !== 5'd7 || flip_j !== 5'd12) begin errs++; $display("FAIL single_flip got=%b %0d %0d want=1 7 12", flip_valid, flip_i, flip_j); end
    checks++; if (held_valid !== 1'b0 || q !== 32'h0) begin errs++; $display("FAIL single_mid got=%b %h want=0 0", held_valid, q); end
    tick();
    @(negedge clk);
    checks++; if (q !== 32'h0000_1080) begin errs++; $display("FAIL single_q got=%h want=00001080", q); end
    checks++; if (flip_valid !== 1'b0) begin errs++; $display("FAIL single_pulse got=%b want=0", flip_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(4'b1010, pk(0, 3, 0, 31));
    @(negedge clk);
    checks++; if (req_ready !== 4'b1010) begin errs++; $display("FAIL pair_ready got=%b want=1010", req_ready); end
    tick();
    @(negedge clk);
    checks++; if (flip_valid !== 1'b1 || flip_i !== 5'd3 || flip_j !== 5'd31) begin errs++; $display("FAIL pair_flip got=%b %0d %0d want=1 3 31", flip_valid, flip_i, flip_j); end
    checks++; if (req_ready !== 4'b1010) begin errs++; $display("FAIL pair_ready2 got=%b want=1010", req_ready); end
    tick();
    drive(4'b0, '0);
    @(negedge clk);
    checks++; if (q !== 32'h8000_0008) begin errs++; $display("FAIL pair_q got=%h want=80000008", q); end
    checks++; if (flip_valid !== 1'b1) begin errs++; $display("FAIL pair_flip2 got=%b want=1", flip_valid); end
    tick();
    @(negedge clk);
    checks++; if (q !== 32'h0) begin errs++; $display("FAIL pair_q_back got=%h want=0", q); end
    tick();
  endtask

  task automatic test_cancel();
    do_reset();
    drive(4'b0001, pk(5, 0, 0, 0));
    tick();
    @(negedge clk);
    checks++; if (held_valid !== 1'b1 || held_idx !== 5'd5) begin errs++; $display("FAIL cancel_held got=%b/%0d want=1/5", held_valid, held_idx); end
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL cancel_ready got=%b want=0001", req_ready); end
    tick();
    drive(4'b0, '0);
    @(negedge clk);
    checks++; if (cancel_pulse !== 1'b1 || flip_valid !== 1'b0) begin errs++; $display("FAIL cancel_pulse got=%b/%b want=1/0", cancel_pulse, flip_valid); end
    checks++; if (held_valid !== 1'b0) begin errs++; $display("FAIL cancel_clear got=%b want=0", held_valid); end
    tick();
    @(negedge clk);
    checks++; if (cancel_pulse !== 1'b0 || q !== 32'h0) begin errs++; $display("FAIL cancel_after got=%b %h want=0 0", cancel_pulse, q); end
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] seq [3] = '{4'b0011, 4'b1100, 4'b0011};
    do_reset();
    drive(4'hF, pk(1, 2, 3, 4));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== seq[i]) begin errs++; $display("FAIL fair_rr%0d got=%b want=%b", i, req_ready, seq[i]); end
      tick();
    end
    drive(4'b0001, pk(1, 2, 3, 4));
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL fair_lone got=%b want=0001", req_ready); end
    tick();
    drive(4'hF, pk(1, 2, 3, 4));
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL fair_budget1 got=%b want=0010", req_ready); end
    tick();
    @(negedge clk);
    checks++; if (held_valid !== 1'b0 || req_ready !== 4'b1100) begin errs++; $display("FAIL fair_budget2 got=%b/%b want=0/1100", held_valid, req_ready); end
    tick();
    drive(4'b0, '0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b0100, pk(0, 0, 9, 0));
    tick();
    drive(4'b0, '0);
    @(negedge clk);
    checks++; if (held_valid !== 1'b1 || held_idx !== 5'd9) begin errs++; $display("FAIL mid_held got=%b/%0d want=1/9", held_valid, held_idx); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (held_valid !== 1'b0 || q !== 32'h0 || flip_valid !== 1'b0) begin errs++; $display("FAIL mid_reset1 got=%b %h %b want=0 0 0", held_valid, q, flip_valid); end
    drive(4'b0011, pk(4, 6, 0, 0));
    tick();
    drive(4'b0011, pk(8, 10, 0, 0));
    tick();
    drive(4'b0, '0);
    @(negedge clk);
    checks++; if (q !== 32'h50 || flip_valid !== 1'b1) begin errs++; $display("FAIL mid_inflight got=%h %b want=50 1", q, flip_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (held_valid !== 1'b0 || q !== 32'h0 || flip_valid !== 1'b0) begin errs++; $display("FAIL mid_reset2 got=%b %h %b want=0 0 0", held_valid, q, flip_valid); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] cur_v = '0;
    logic [19:0] cur_idx = '0;
    int wt [4] = '{0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 4; k++)
        if (!cur_v[k] && $urandom_range(0, 2) == 0) begin
          cur_v[k] = 1'b1;
          cur_idx[k*5 +: 5] = 5'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 3 : 31));
        end
      rst_n = ($urandom_range(0, 59) != 0);
      drive(cur_v, cur_idx);
      @(negedge clk);
      model_grant();
      checks++; if (req_ready !== exp_ready) begin errs++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
      checks++; if (q !== m_q) begin errs++; $display("FAIL rnd_q c=%0d got=%h want=%h", c, q, m_q); end
      checks++; if (^q !== 1'b0) begin errs++; $display("FAIL rnd_parity c=%0d got=%b want=0", c, ^q); end
      checks++; if (flip_valid !== m_fv || cancel_pulse !== m_cp) begin errs++; $display("FAIL rnd_pulses c=%0d got=%b%b want=%b%b", c, flip_valid, cancel_pulse, m_fv, m_cp); end
      if (m_fv) begin
        checks++; if (flip_i !== 5'(m_fi) || flip_j !== 5'(m_fj)) begin errs++; $display("FAIL rnd_pair c=%0d got=%0d,%0d want=%0d,%0d", c, flip_i, flip_j, m_fi, m_fj); end
      end
      checks++; if (held_valid !== m_hv) begin errs++; $display("FAIL rnd_held c=%0d got=%b want=%b", c, held_valid, m_hv); end
      if (m_hv) begin
        checks++; if (held_idx !== 5'(m_hi)) begin errs++; $display("FAIL rnd_held_idx c=%0d got=%0d want=%0d", c, held_idx, m_hi); end
      end
      for (int k = 0; k < 4; k++) begin
        wt[k] = (rst_n && cur_v[k] && !req_ready[k]) ? wt[k] + 1 : 0;
        checks++; if (wt[k] >= 4) begin errs++; $display("FAIL rnd_starve c=%0d req=%0d got_wait=%0d want_below=4", c, k, wt[k]); end
        if (rst_n && req_ready[k]) cur_v[k] = 1'b0;
      end
      tick();
    end
    rst_n = 1'b1;
    drive(4'b0, '0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cancel();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
